// File: rtl/ctr_plaintext_packer.sv
// Packs a narrow valid/ready plaintext word stream into BUF_W-bit buffers for the AES-CTR stage.
// Optional CTR_PACK_BYTESWAP_EN: treat each input word as little-endian (in_data[7:0] is the first byte).
module ctr_plaintext_packer #(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WORD_W-1:0]              in_data,
    input  logic [$clog2(WORD_W/8):0]      in_keep,
    input  logic                           in_last,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [BUF_W-1:0]               pt_out,
    output logic [$clog2(BUF_W/8):0]       pt_bytes,
    output logic [$clog2(BUF_W/128):0]     pt_blocks,
    output logic                           pt_last,
    output logic                           pt_valid,
    input  logic                           pt_ready,
    output logic                           o_dbg_state
);

    localparam int WB      = WORD_W / 8;
    localparam int NW      = BUF_W / WORD_W;
    localparam int IDX_W   = $clog2(NW) + 1;
    localparam int KEEP_W  = $clog2(WB) + 1;
    localparam int BYTES_W = $clog2(BUF_W / 8) + 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [BUF_W-1:0]     r_buf;
    logic [BYTES_W-1:0]   r_bytes;
    logic                 r_last;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_done;
    logic [KEEP_W-1:0]    w_keep;
    logic [WORD_W-1:0]    w_word;
    logic [BYTES_W-1:0]   w_blk_sum;

    // Handshakes: a word moves on a rising edge with in_valid & in_ready, a buffer
    // moves on a rising edge with pt_valid & pt_ready; valid never waits on ready.
    assign in_ready    = (r_state == FILL) && rst;
    assign pt_valid    = (r_state == HOLD);
    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = pt_valid && pt_ready;
    assign w_done      = w_in_xfer && (in_last || (r_idx == IDX_W'(NW - 1)));

    assign pt_out      = r_buf;
    assign pt_bytes    = r_bytes;
    assign pt_last     = r_last;
    assign w_blk_sum   = r_bytes + BYTES_W'(15);
    assign pt_blocks   = w_blk_sum[BYTES_W-1:4];
    assign o_dbg_state = r_state;

    always_comb begin
        w_keep = KEEP_W'(WB);
        if (in_last && (in_keep < KEEP_W'(WB))) begin
            w_keep = in_keep;
        end
    end

    // Lane 0 is the first byte in stream order; it always lands at the word MSB.
    always_comb begin
        w_word = '0;
        for (int b = 0; b < WB; b++) begin
            if (KEEP_W'(b) < w_keep) begin
`ifdef CTR_PACK_BYTESWAP_EN
                w_word[WORD_W-1-8*b -: 8] = in_data[8*b +: 8];
`else
                w_word[WORD_W-1-8*b -: 8] = in_data[WORD_W-1-8*b -: 8];
`endif
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_done) w_next = HOLD;
            HOLD:    if (pt_ready) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_buf   <= '0;
            r_bytes <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_xfer) begin
                for (int k = 0; k < NW; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_buf[BUF_W-1-k*WORD_W -: WORD_W] <= w_word;
                    end
                end
                r_idx   <= r_idx + IDX_W'(1);
                r_bytes <= r_bytes + BYTES_W'(w_keep);
                if (w_done) begin
                    r_last <= in_last;
                end
            end else if (w_out_xfer) begin
                r_idx   <= '0;
                r_buf   <= '0;
                r_bytes <= '0;
                r_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctr_plaintext_packer.sv
// Randomized scoreboard bench for ctr_plaintext_packer; the reference model packs
// messages byte-by-byte into expected buffers.
module tb_ctr_plaintext_packer;

  localparam int WORD_W  = 32;
  localparam int BUF_W   = 1024;
  localparam int WB      = WORD_W / 8;
  localparam int NW      = BUF_W / WORD_W;
  localparam int KEEP_W  = $clog2(WB) + 1;
  localparam int BYTES_W = $clog2(BUF_W / 8) + 1;
  localparam int BLK_W   = $clog2(BUF_W / 128) + 1;
  localparam int EXP_W   = BUF_W + BYTES_W + BLK_W + 1;

  logic                clk;
  logic                rst;
  logic [WORD_W-1:0]   in_data;
  logic [KEEP_W-1:0]   in_keep;
  logic                in_last;
  logic                in_valid;
  logic                in_ready;
  logic [BUF_W-1:0]    pt_out;
  logic [BYTES_W-1:0]  pt_bytes;
  logic [BLK_W-1:0]    pt_blocks;
  logic                pt_last;
  logic                pt_valid;
  logic                pt_ready;
  logic                dbg_state;

  ctr_plaintext_packer #(.WORD_W(WORD_W), .BUF_W(BUF_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_keep     (in_keep),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pt_out      (pt_out),
    .pt_bytes    (pt_bytes),
    .pt_blocks   (pt_blocks),
    .pt_last     (pt_last),
    .pt_valid    (pt_valid),
    .pt_ready    (pt_ready),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [WORD_W-1:0] msg_w [0:127];
  logic [EXP_W-1:0]  exp_q [$];
  int                n_checks = 0;
  int                n_pass   = 0;
  bit                hold_all = 1'b0;
  int                bp_cycles = 0;
  bit                prev_hold = 1'b0;
  logic [EXP_W-1:0]  prev_snap;

  function automatic logic [EXP_W-1:0] out_vec();
    return {pt_out, pt_bytes, pt_blocks, pt_last};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_buf(input string name, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    int  s;
    bit  found;
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      s = 0;
      found = 1'b0;
      for (int i = 0; i < BUF_W / 128; i++) begin
        if (!found && (got[EXP_W-1-128*i -: 128] !== exp[EXP_W-1-128*i -: 128])) begin
          s = i;
          found = 1'b1;
        end
      end
      $display("FAIL %s: slice %0d got %h expected %h; bytes got %0d expected %0d; blocks got %0d expected %0d; last got %0d expected %0d",
               name, s, got[EXP_W-1-128*s -: 128], exp[EXP_W-1-128*s -: 128],
               got[BLK_W+1 +: BYTES_W], exp[BLK_W+1 +: BYTES_W],
               got[1 +: BLK_W], exp[1 +: BLK_W], got[0], exp[0]);
    end
  endtask

  // ---------------- reference model ----------------
  // Message = msg_w[0..n-1]; every word but the last carries WB bytes, the last
  // carries min(last_keep, WB). Each run of NW word slots forms one buffer.
  task automatic build_expect(input int n, input int last_keep);
    int               wi;
    int               ce;
    int               nb;
    int               k;
    logic [BUF_W-1:0] bufv;
    logic [7:0]       b;
    wi = 0;
    while (wi < n) begin
      ce = (wi + NW < n) ? wi + NW : n;
      bufv = '0;
      nb = 0;
      for (int w = wi; w < ce; w++) begin
        k = (w == n - 1) ? ((last_keep > WB) ? WB : last_keep) : WB;
        for (int j = 0; j < k; j++) begin
`ifdef CTR_PACK_BYTESWAP_EN
          b = msg_w[w][8*j +: 8];
`else
          b = msg_w[w][WORD_W-1-8*j -: 8];
`endif
          bufv[BUF_W-1-8*nb -: 8] = b;
          nb++;
        end
      end
      exp_q.push_back({bufv, BYTES_W'(nb), BLK_W'((nb + 15) / 16), (ce == n)});
      wi = ce;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_msg(input int n, input int last_keep, input bit push, input int abort_after);
    int t;
    if (push) build_expect(n, last_keep);
    for (int i = 0; i < n && i < abort_after; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_data  = msg_w[i];
      in_last  = (i == n - 1);
      in_keep  = (i == n - 1) ? KEEP_W'(last_keep) : KEEP_W'($urandom_range(0, 7));
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) begin
        n_checks++;
        $display("FAIL in_ready_timeout: in_ready got 0 for 500 cycles, expected 1");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) msg_w[i] = $urandom;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic rdy;
    if (!rst) begin
      prev_hold = 1'b0;
      pt_ready  = 1'b0;
    end else begin
      if (prev_hold) chk_buf("hold_stable", out_vec(), prev_snap);
      if (pt_valid) chk("in_ready_low_in_hold", in_ready, 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (hold_all) begin
        rdy = 1'b0;
      end else if (pt_valid && bp_cycles > 0) begin
        rdy = 1'b0;
        bp_cycles--;
      end
      pt_ready = rdy;
      if (pt_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_buffer: got buffer bytes %0d last %0d, expected none", pt_bytes, pt_last);
        end else begin
          chk_buf("buffer", out_vec(), exp_q.pop_front());
        end
        prev_hold = 1'b0;
      end else begin
        prev_hold = pt_valid;
        prev_snap = out_vec();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    chk("reset_pt_valid", pt_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk_buf("reset_outputs", out_vec(), '0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_pt_valid", pt_valid, 0);

    // short message, fixed expectation
`ifdef CTR_PACK_BYTESWAP_EN
    msg_w[0] = 32'h67452301;
    msg_w[1] = 32'hefcdab89;
`else
    msg_w[0] = 32'h01234567;
    msg_w[1] = 32'h89abcdef;
`endif
    exp_q.push_back({64'h0123456789abcdef, {(BUF_W-64){1'b0}}, BYTES_W'(8), BLK_W'(1), 1'b1});
    send_msg(2, 4, 1'b0, 2);
    wait_drain();

    // exact fill: last word in the final slot, no trailing empty buffer
    for (int i = 0; i < 32; i++) msg_w[i] = i;
    send_msg(32, 4, 1'b1, 32);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("no_trailing_buffer", pt_valid, 0);

    // overflow split into a second, 1-byte buffer
    for (int i = 0; i < 32; i++) msg_w[i] = $urandom;
    msg_w[32] = 32'hAABBCCDD;
    send_msg(33, 1, 1'b1, 33);
    wait_drain();

    // empty last word as the first word
    msg_w[0] = $urandom;
    send_msg(1, 0, 1'b1, 1);
    wait_drain();

    // in_keep above word width is clamped
    rand_words(3);
    send_msg(3, 7, 1'b1, 3);
    wait_drain();

    // backpressure: 10 held cycles with the next message already waiting
    bp_cycles = 10;
    rand_words(32);
    send_msg(32, 4, 1'b1, 32);
    rand_words(5);
    send_msg(5, 2, 1'b1, 5);
    wait_drain();

    // randomized messages
    repeat (12) begin
      int n;
      int k;
      n = $urandom_range(1, 70);
      k = $urandom_range(0, 7);
      rand_words(n);
      send_msg(n, k, 1'b1, n);
    end
    wait_drain();

    // reset mid-fill after 5 words, then a 2-word message lands at the MSB
    rand_words(10);
    send_msg(10, 4, 1'b0, 5);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midfill_reset_in_ready", in_ready, 0);
    chk_buf("midfill_reset_outputs", out_vec(), '0);
    rst = 1'b1;
    @(negedge clk);
`ifdef CTR_PACK_BYTESWAP_EN
    msg_w[0] = 32'h67452301;
    msg_w[1] = 32'hefcdab89;
`else
    msg_w[0] = 32'h01234567;
    msg_w[1] = 32'h89abcdef;
`endif
    exp_q.push_back({64'h0123456789abcdef, {(BUF_W-64){1'b0}}, BYTES_W'(8), BLK_W'(1), 1'b1});
    send_msg(2, 4, 1'b0, 2);
    wait_drain();

    // reset mid-hold discards the held buffer
    hold_all = 1'b1;
    rand_words(3);
    send_msg(3, 4, 1'b0, 3);
    t = 0;
    while (!pt_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("midhold_reached_hold", pt_valid, 1);
    rst = 1'b0;
    hold_all = 1'b0;
    repeat (2) @(negedge clk);
    chk("midhold_reset_pt_valid", pt_valid, 0);
    chk_buf("midhold_reset_outputs", out_vec(), '0);
    rst = 1'b1;
    @(negedge clk);
    rand_words(6);
    send_msg(6, 3, 1'b1, 6);
    wait_drain();

    repeat (10) @(negedge clk);
    chk("final_idle_pt_valid", pt_valid, 0);
    chk("final_idle_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
